// File: rtl/icache_refill_pkg.sv
// Shared instruction-cache line geometry and refill FSM encoding.
// Imported by the cache and the refill engine so both agree on line size.
package icache_refill_pkg;

  localparam int ICACHE_BLOCK_WIDTH = 4;
  localparam int ICACHE_BLOCK_SIZE  = 2 ** ICACHE_BLOCK_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_DONE
  } refill_state_e;

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache line refill: reads a line byte-by-byte from RAM
// and hands it to the cache as a single one-cycle block write.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter  int BLOCK_WIDTH = ICACHE_BLOCK_WIDTH,
  localparam int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic                    clearIn,
  input  logic                    missIn,
  input  logic [31:0]             missAddrIn,
  input  logic                    memGrantIn,
  input  logic [7:0]              ramDataIn,
  output logic                    memReqOut,
  output logic [31:0]             ramAddrOut,
  output logic                    ramReadEnable,
  output logic                    memDataValid,
  output logic [31:BLOCK_WIDTH]   memAddr,
  output logic [BLOCK_SIZE*8-1:0] memDataOut,
  output logic                    busy
);

  localparam logic [BLOCK_WIDTH:0] CNT_ONE  = 1;
  localparam logic [BLOCK_WIDTH:0] CNT_LAST = BLOCK_SIZE - 1;

  refill_state_e              state_q, state_d;
  logic [31:BLOCK_WIDTH]      lineAddr_q, lineAddr_d;
  logic [BLOCK_WIDTH:0]       issueCnt_q, issueCnt_d;
  logic [BLOCK_WIDTH:0]       recvCnt_q, recvCnt_d;
  logic [BLOCK_SIZE*8-1:0]    lineBuf_q, lineBuf_d;
  logic [31:0]                ramAddr_q, ramAddr_d;
  logic [31:BLOCK_WIDTH]      memAddr_q, memAddr_d;
  logic [BLOCK_SIZE*8-1:0]    memData_q, memData_d;

  logic unused_offset;
  assign unused_offset = ^missAddrIn[BLOCK_WIDTH-1:0];

  always_comb begin
    state_d       = state_q;
    lineAddr_d    = lineAddr_q;
    issueCnt_d    = issueCnt_q;
    recvCnt_d     = recvCnt_q;
    lineBuf_d     = lineBuf_q;
    ramAddr_d     = ramAddr_q;
    memAddr_d     = memAddr_q;
    memData_d     = memData_q;
    memReqOut     = 1'b0;
    ramReadEnable = 1'b0;
    memDataValid  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (missIn && !clearIn) begin
          lineAddr_d = missAddrIn[31:BLOCK_WIDTH];
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        memReqOut = 1'b1;
        if (clearIn) begin
          state_d = ST_IDLE;
        end else if (memGrantIn) begin
          issueCnt_d = '0;
          recvCnt_d  = '0;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        memReqOut = 1'b1;
        if (!issueCnt_q[BLOCK_WIDTH]) begin
          ramReadEnable = 1'b1;
          ramAddr_d     = {lineAddr_q, issueCnt_q[BLOCK_WIDTH-1:0]};
          issueCnt_d    = issueCnt_q + CNT_ONE;
        end
        // RAM data lags the address by one cycle, so capture starts late
        if (issueCnt_q != '0) begin
          lineBuf_d[{recvCnt_q[BLOCK_WIDTH-1:0], 3'b000} +: 8] = ramDataIn;
          recvCnt_d = recvCnt_q + CNT_ONE;
        end
        if (clearIn) begin
          state_d = ST_IDLE;
        end else if (issueCnt_q != '0 && recvCnt_q == CNT_LAST) begin
          memAddr_d = lineAddr_q;
          memData_d = lineBuf_d;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        memDataValid = 1'b1;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state_q    <= ST_IDLE;
      lineAddr_q <= '0;
      issueCnt_q <= '0;
      recvCnt_q  <= '0;
      lineBuf_q  <= '0;
      ramAddr_q  <= '0;
      memAddr_q  <= '0;
      memData_q  <= '0;
    end else begin
      state_q    <= state_d;
      lineAddr_q <= lineAddr_d;
      issueCnt_q <= issueCnt_d;
      recvCnt_q  <= recvCnt_d;
      lineBuf_q  <= lineBuf_d;
      ramAddr_q  <= ramAddr_d;
      memAddr_q  <= memAddr_d;
      memData_q  <= memData_d;
    end
  end

  assign ramAddrOut = ramAddr_d;
  assign memAddr    = memAddr_q;
  assign memDataOut = memData_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: table of refills plus
// hand-written flush, reset and idle-blocking sequences.
module tb_icache_refill;
  import icache_refill_pkg::*;

  localparam int BW = ICACHE_BLOCK_WIDTH;
  localparam int BS = ICACHE_BLOCK_SIZE;

  logic            clk = 1'b0;
  logic            rst, clr, miss, grant_en;
  logic [31:0]     maddr;
  logic            gnt;
  logic [7:0]      rdata;
  logic            memReqOut, ramReadEnable, memDataValid, busy;
  logic [31:0]     ramAddrOut;
  logic [31:BW]    memAddr;
  logic [BS*8-1:0] memDataOut;

  int tests = 0;
  int fails = 0;

  icache_refill dut (
    .clkIn        (clk),
    .resetIn      (rst),
    .clearIn      (clr),
    .missIn       (miss),
    .missAddrIn   (maddr),
    .memGrantIn   (gnt),
    .ramDataIn    (rdata),
    .memReqOut    (memReqOut),
    .ramAddrOut   (ramAddrOut),
    .ramReadEnable(ramReadEnable),
    .memDataValid (memDataValid),
    .memAddr      (memAddr),
    .memDataOut   (memDataOut),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Arbiter grants only while requested; RAM byte = addr[7:0] ^ 0x20
  assign gnt = memReqOut & grant_en;

  always @(posedge clk)
    rdata <= ramReadEnable ? (ramAddrOut[7:0] ^ 8'h20) : 8'hEE;

  typedef struct {
    logic [31:0]     addr;
    int              gd;
    bit              clr_done;
    bit              chg;
    logic [31:BW]    exp_la;
    logic [BS*8-1:0] exp_data;
    int              exp_lat;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, lat, nrd, bad, early, drop;
    logic [31:BW]    la;
    logic [BS*8-1:0] d;
    cyc = 0; lat = -1; nrd = 0; bad = 0; early = 0; drop = 0;
    la = '0; d = '0;
    @(negedge clk);
    miss = 1'b1; maddr = v.addr; grant_en = 1'b0;
    while (lat < 0 && cyc < 80) begin
      @(posedge clk);
      cyc++;
      #1;
      miss = 1'b0;
      if (cyc >= v.gd + 1) grant_en = 1'b1;
      if (v.chg && cyc == 6) maddr = 32'h0000_5550;
      if (v.clr_done && cyc == v.exp_lat) clr = 1'b1;
      #1;
      if (ramReadEnable) begin
        if (cyc <= v.gd + 1) early++;
        if (ramAddrOut !== {v.addr[31:BW], nrd[BW-1:0]}) bad++;
        nrd++;
      end
      if (!memDataValid && !memReqOut) drop++;
      if (memDataValid) begin
        lat = cyc; la = memAddr; d = memDataOut;
      end
    end
    chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d memAddr", idx), la, v.exp_la);
    chk($sformatf("v%0d memDataOut", idx), d, v.exp_data);
    chk($sformatf("v%0d reads", idx), nrd, BS);
    chk($sformatf("v%0d bad addrs", idx), bad, 0);
    chk($sformatf("v%0d early reads", idx), early, 0);
    chk($sformatf("v%0d req dropped", idx), drop, 0);
    @(posedge clk);
    #1 clr = 1'b0;
    #1;
    chk($sformatf("v%0d pulse width", idx), memDataValid, 1'b0);
    chk($sformatf("v%0d busy after", idx), busy, 1'b0);
    chk($sformatf("v%0d data held", idx), memDataOut, v.exp_data);
  endtask

  task automatic start_miss(input logic [31:0] a);
    @(negedge clk);
    miss = 1'b1; maddr = a; grant_en = 1'b1;
    @(posedge clk);
    #1 miss = 1'b0;
  endtask

  initial begin
    int nval;
    vt[0] = '{32'h0000_0040, 0, 1'b0, 1'b0, 28'h0000004,
              128'h6F6E6D6C6B6A69686766656463626160, 19};
    vt[1] = '{32'h0000_1234, 0, 1'b0, 1'b0, 28'h0000123,
              128'h1F1E1D1C1B1A19181716151413121110, 19};
    vt[2] = '{32'h0000_1234, 5, 1'b0, 1'b0, 28'h0000123,
              128'h1F1E1D1C1B1A19181716151413121110, 24};
    vt[3] = '{32'h00AB_CDE8, 1, 1'b1, 1'b0, 28'h00ABCDE,
              128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0, 20};
    vt[4] = '{32'hFFFF_FFFC, 0, 1'b0, 1'b1, 28'hFFFFFFF,
              128'hDFDEDDDCDBDAD9D8D7D6D5D4D3D2D1D0, 19};

    rst = 1'b1; clr = 1'b0; miss = 1'b0;
    maddr = '0; grant_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ctrl", {memReqOut, ramReadEnable, memDataValid, busy}, 4'b0);
    chk("reset ramAddr", ramAddrOut, 32'h0);
    chk("reset memAddr", memAddr, 28'h0);
    chk("reset memData", memDataOut, 128'h0);
    @(negedge clk);
    rst = 1'b0;

    // clear and miss together in IDLE must not start a refill
    miss = 1'b1; clr = 1'b1; maddr = 32'h0000_3000; grant_en = 1'b1;
    @(posedge clk);
    #1 miss = 1'b0; clr = 1'b0;
    chk("idle clear blocks", busy, 1'b0);

    // flush on FILL cycle 7 (cycle 8 after the miss with immediate grant)
    start_miss(32'h0000_2000);
    repeat (7) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("flush busy", busy, 1'b0);
    chk("flush req", memReqOut, 1'b0);
    chk("flush rden", ramReadEnable, 1'b0);
    nval = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (memDataValid) nval++;
    end
    chk("flush no valid", nval, 0);

    for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

    // synchronous reset on FILL cycle 3 clears everything next cycle
    start_miss(32'h0000_1234);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midfill rst ctrl",
        {memReqOut, ramReadEnable, memDataValid, busy}, 4'b0);
    chk("midfill rst ramAddr", ramAddrOut, 32'h0);
    chk("midfill rst memAddr", memAddr, 28'h0);
    chk("midfill rst memData", memDataOut, 128'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("midfill rst idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Fetches a missing instruction-cache line from the byte-wide RAM port and delivers it to the instruction cache as one block write.
- Sits between the instruction cache (upstream consumer of the fill) and the memory arbiter/RAM.
- On a miss, it requests the RAM port, reads BLOCK_SIZE consecutive bytes, and assembles them little-endian.
- It then pulses memDataValid with the line address and data for exactly one cycle.

Parameters:
- BLOCK_WIDTH, 4, log2 of line size in bytes.
- BLOCK_SIZE, 2**BLOCK_WIDTH, line size in bytes.

Ports:
- clkIn  input  1  system clock.
- resetIn  input  1  synchronous, active-high reset.
- clearIn  input  1  pipeline flush; aborts an unfinished refill.
- missIn  input  1  cache miss for missAddrIn.
- missAddrIn  input  32  instruction address that missed.
- memGrantIn  input  1  arbiter grant of RAM port; held high until memReqOut drops.
- ramDataIn  input  8  RAM read data; corresponds to the address driven in the previous cycle.
- memReqOut  output  1  RAM port request.
- ramAddrOut  output  32  RAM byte address.
- ramReadEnable  output  1  read strobe; a byte is issued this cycle.
- memDataValid  output  1  one-cycle line-write pulse to the cache.
- memAddr  output  [31:BLOCK_WIDTH]  line address of the delivered line.
- memDataOut  output  BLOCK_SIZE*8  line data; byte k at bits [8k+7:8k].
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, REQ, FILL, DONE.
- Registers:
  - lineAddr [31:BLOCK_WIDTH].
  - issueCnt, BLOCK_WIDTH+1 bits.
  - recvCnt, BLOCK_WIDTH+1 bits.
  - lineBuf, BLOCK_SIZE*8 bits.
- Reset (any state, including mid-FILL):
  - State goes to IDLE.
  - Zeroes: memReqOut, ramReadEnable, memDataValid, busy, ramAddrOut, memAddr, memDataOut, both counters.
- IDLE:
  - If missIn && !clearIn: latch lineAddr = missAddrIn[31:BLOCK_WIDTH], go to REQ.
  - Otherwise stay.
- REQ:
  - memReqOut=1.
  - When memGrantIn=1, go to FILL with issueCnt=0 and recvCnt=0.
  - No RAM read occurs in the grant cycle.
- FILL:
  - memReqOut=1.
  - Each cycle with issueCnt<BLOCK_SIZE: ramReadEnable=1, ramAddrOut={lineAddr, issueCnt[BLOCK_WIDTH-1:0]}, issueCnt++.
  - Each cycle after the first FILL cycle: lineBuf byte[recvCnt] <= ramDataIn, recvCnt++.
  - When the byte with recvCnt==BLOCK_SIZE-1 is captured, go to DONE.
  - FILL lasts BLOCK_SIZE+1 cycles.
  - ramReadEnable=0 in the final FILL cycle.
  - ramAddrOut holds its last value whenever ramReadEnable=0.
- DONE (one cycle):
  - memDataValid=1, memAddr=lineAddr, memDataOut=lineBuf.
  - memReqOut=0.
  - Next state is IDLE.
  - memAddr and memDataOut hold their values until the next DONE.
- Latency:
  - Miss with immediate grant: memDataValid asserts BLOCK_SIZE+3 cycles after missIn is first sampled (19 for default).
  - Grant delay adds cycle-for-cycle.
- clearIn:
  - In REQ or FILL: go to IDLE next cycle and drop memReqOut/ramReadEnable.
  - An in-flight byte is discarded and no memDataValid is produced.
  - In DONE: ignored; the line is still written, because the data is valid regardless of flush.
  - In IDLE: blocks starting a refill that cycle.
  - clearIn and missIn together in IDLE: no refill.
- Only one refill is outstanding. missIn/missAddrIn are ignored outside IDLE; missAddrIn is sampled only on the IDLE->REQ transition.
- Returning from DONE to IDLE: missIn is resampled. The cache has already absorbed the line, so a refill for the same line does not recur.
- Line address and counter concatenation must not carry into lineAddr. A line at 0xFFFFFFF0 reads 0xFFFFFFF0..0xFFFFFFFF and never wraps to 0.

Decomposition:
- Shared package contents:
  - State encoding typedef (IDLE/REQ/FILL/DONE).
  - BLOCK_WIDTH/BLOCK_SIZE defaults, shared with the instruction cache so line geometry is defined once.
- No sub-module: the line-assembly shift/insert logic is inline; a separate module would be a thin wrapper.

Test Plan:
- Basic refill:
  - Stimulus: reset, missIn=1, missAddrIn=0x00001234, grant immediate, RAM[0x1230+k]=k+0x10.
  - Response: ramAddrOut steps 0x1230..0x123F; memDataValid pulse one cycle; memAddr=0x123; memDataOut=0x1F1E...1110; total latency 19.
- Delayed grant:
  - Stimulus: grant held low 5 cycles.
  - Response: memReqOut high throughout; no ramReadEnable before grant; memDataValid at cycle 24.
- Flush mid-fill:
  - Stimulus: clearIn pulsed on FILL cycle 7.
  - Response: IDLE next cycle; memReqOut=0; no memDataValid; a subsequent miss at 0x40 refills correctly from 0x40.
- Flush in DONE:
  - Stimulus: clearIn in the DONE cycle.
  - Response: memDataValid still 1 with the correct line.
- Reset mid-fill:
  - Stimulus: resetIn on FILL cycle 3.
  - Response: all outputs 0 next cycle; state IDLE.
- Top-of-memory line and ignored miss:
  - Stimulus: miss at 0xFFFFFFFC.
  - Response: addresses 0xFFFFFFF0..0xFFFFFFFF; memAddr=0xFFFFFFF; missAddrIn changes during FILL are ignored.
